// File: rtl/uart_text_receiver.sv
// 8N1 UART receiver feeding a four-row, sixteen-column text buffer whose rows
// drive the 128-bit string inputs of the OLED driver (column 0 is the MSB byte).
module uart_text_receiver #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic         GCLK,
  input  logic         RST,
  input  logic         RX,
  output logic [127:0] LINE0,
  output logic [127:0] LINE1,
  output logic [127:0] LINE2,
  output logic [127:0] LINE3,
  output logic [7:0]   RX_BYTE,
  output logic         RX_VALID,
  output logic         FRAME_ERR,
  output logic [1:0]   CUR_ROW,
  output logic [3:0]   CUR_COL
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);
  localparam logic [127:0]  BLANK     = {16{8'h20}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    idx, idx_next;
  logic [7:0]    shift, shift_next;
  logic          byte_done, frame_bad;
  logic          rx_meta, rx_sync;

  logic [127:0]  lines [4];
  logic [1:0]    row;
  logic [3:0]    col;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge GCLK) begin
    // NOTE: every clocked register uses <= so all flops update from pre-edge values.
    if (RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    byte_done  = 1'b0;
    frame_bad  = 1'b0;
    unique case (state)
      IDLE: if (!rx_sync) begin
        state_next = START;
        cnt_next   = HALF_LOAD;
      end
      START: if (cnt == '0) begin
        if (!rx_sync) begin
          state_next = DATA;
          cnt_next   = FULL_LOAD;
          idx_next   = 3'd0;
        end else begin
          state_next = IDLE;
        end
      end else begin
        cnt_next = cnt - CW'(1);
      end
      DATA: if (cnt == '0) begin
        shift_next = {rx_sync, shift[7:1]};
        cnt_next   = FULL_LOAD;
        if (idx == 3'd7) state_next = STOP;
        else             idx_next   = idx + 3'd1;
      end else begin
        cnt_next = cnt - CW'(1);
      end
      STOP: if (cnt == '0) begin
        // Leaving at mid-stop lets a back-to-back start edge be caught.
        state_next = IDLE;
        byte_done  = rx_sync;
        frame_bad  = !rx_sync;
      end else begin
        cnt_next = cnt - CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge GCLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      RX_BYTE   <= 8'h00;
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      shift     <= shift_next;
      if (byte_done) RX_BYTE <= shift;
      RX_VALID  <= byte_done;
      FRAME_ERR <= frame_bad;
    end
  end

  logic [3:0] col_m1;
  logic [6:0] wr_lo, bs_lo;
  logic [1:0] row_p1;

  assign col_m1 = col - 4'd1;
  assign wr_lo  = 7'd120 - {col, 3'b000};
  assign bs_lo  = 7'd120 - {col_m1, 3'b000};
  assign row_p1 = row + 2'd1;

  always_ff @(posedge GCLK) begin
    if (RST) begin
      // NOTE: the text buffer is reset because the display must show blanks, not garbage.
      for (int i = 0; i < 4; i++) lines[i] <= BLANK;
      row <= 2'd0;
      col <= 4'd0;
    end else if (RX_VALID) begin
      if (RX_BYTE >= 8'h20 && RX_BYTE <= 8'h7E) begin
        lines[row][wr_lo +: 8] <= RX_BYTE;
        col <= col + 4'd1;
        if (col == 4'd15) begin
          row            <= row_p1;
          lines[row_p1]  <= BLANK;
        end
      end else begin
        case (RX_BYTE)
          8'h0D: col <= 4'd0;
          8'h0A: begin
            col           <= 4'd0;
            row           <= row_p1;
            lines[row_p1] <= BLANK;
          end
          8'h08: if (col != 4'd0) begin
            col                    <= col_m1;
            lines[row][bs_lo +: 8] <= 8'h20;
          end
          8'h0C: begin
            for (int i = 0; i < 4; i++) lines[i] <= BLANK;
            row <= 2'd0;
            col <= 4'd0;
          end
          default: ;
        endcase
      end
    end
  end

  assign LINE0   = lines[0];
  assign LINE1   = lines[1];
  assign LINE2   = lines[2];
  assign LINE3   = lines[3];
  assign CUR_ROW = row;
  assign CUR_COL = col;

endmodule

// File: tb/tb_uart_text_receiver.sv
// Directed bench for uart_text_receiver at DIV=10: a table of single-byte text
// engine vectors plus hand-written sequences for wrap, framing, glitch and reset.
module tb_uart_text_receiver;

  localparam logic [127:0] BLANK = {16{8'h20}};

  logic         GCLK = 1'b0;
  logic         RST  = 1'b1;
  logic         RX   = 1'b1;
  logic [127:0] LINE0, LINE1, LINE2, LINE3;
  logic [7:0]   RX_BYTE;
  logic         RX_VALID, FRAME_ERR;
  logic [1:0]   CUR_ROW;
  logic [3:0]   CUR_COL;

  uart_text_receiver #(.CLK_HZ(1000000), .BAUD(100000)) dut (
    .GCLK(GCLK), .RST(RST), .RX(RX),
    .LINE0(LINE0), .LINE1(LINE1), .LINE2(LINE2), .LINE3(LINE3),
    .RX_BYTE(RX_BYTE), .RX_VALID(RX_VALID), .FRAME_ERR(FRAME_ERR),
    .CUR_ROW(CUR_ROW), .CUR_COL(CUR_COL)
  );

  always #5 GCLK = ~GCLK;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_ferr = 0;

  always @(negedge GCLK) begin
    if (RX_VALID === 1'b1) n_valid++;
    if (FRAME_ERR === 1'b1) n_ferr++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Holds RX at v for n clocks; called and returns on a falling edge.
  task automatic drive(input logic v, input int n);
    RX = v;
    repeat (n) @(negedge GCLK);
  endtask

  task automatic idle(input int n);
    drive(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive(1'b0, 10);
    for (int i = 0; i < 8; i++) drive(b[i], 10);
    if (stop_bit) drive(1'b1, 10);
    else begin
      drive(1'b0, 8);
      drive(1'b1, 2);
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [1:0] row;
    logic [3:0] col;
  } vec_t;

  vec_t vecs [12];
  int   v0, f0;

  initial begin
    vecs[0]  = '{8'h0C, 2'd0, 4'd0};
    vecs[1]  = '{8'h48, 2'd0, 4'd1};
    vecs[2]  = '{8'h69, 2'd0, 4'd2};
    vecs[3]  = '{8'h08, 2'd0, 4'd1};
    vecs[4]  = '{8'h08, 2'd0, 4'd0};
    vecs[5]  = '{8'h08, 2'd0, 4'd0};
    vecs[6]  = '{8'h5A, 2'd0, 4'd1};
    vecs[7]  = '{8'h0D, 2'd0, 4'd0};
    vecs[8]  = '{8'h0A, 2'd1, 4'd0};
    vecs[9]  = '{8'h01, 2'd1, 4'd0};
    vecs[10] = '{8'h7E, 2'd1, 4'd1};
    vecs[11] = '{8'h7F, 2'd1, 4'd1};

    @(negedge GCLK);
    repeat (4) @(negedge GCLK);
    RST = 1'b0;
    @(negedge GCLK);
    check("reset LINE0", LINE0, BLANK);
    check("reset LINE3", LINE3, BLANK);
    check("reset RX_BYTE", RX_BYTE, 8'h00);
    check("reset RX_VALID", RX_VALID, 1'b0);
    check("reset FRAME_ERR", FRAME_ERR, 1'b0);
    check("reset cursor", {CUR_ROW, CUR_COL}, 6'd0);

    // "Hi" from reset
    idle(10);
    v0 = n_valid;
    send(8'h48);
    send(8'h69);
    idle(20);
    check("Hi LINE0", LINE0, {16'h4869, {14{8'h20}}});
    check("Hi CUR_COL", CUR_COL, 4'd2);
    check("Hi pulses", n_valid - v0, 2);

    for (int i = 0; i < 12; i++) begin
      v0 = n_valid;
      send(vecs[i].data);
      idle(20);
      check($sformatf("vec%0d row", i), CUR_ROW, vecs[i].row);
      check($sformatf("vec%0d col", i), CUR_COL, vecs[i].col);
      check($sformatf("vec%0d byte", i), RX_BYTE, vecs[i].data);
      check($sformatf("vec%0d pulse", i), n_valid - v0, 1);
    end
    check("table LINE0", LINE0, {8'h5A, {15{8'h20}}});
    check("table LINE1", LINE1, {8'h7E, {15{8'h20}}});

    // 17 x 'A' wraps to row 1
    send(8'h0C);
    for (int i = 0; i < 17; i++) send(8'h41);
    idle(20);
    check("17A LINE0", LINE0, {16{8'h41}});
    check("17A LINE1", LINE1, {8'h41, {15{8'h20}}});
    check("17A cursor", {CUR_ROW, CUR_COL}, {2'd1, 4'd1});

    // Backspace overwrite
    send(8'h0C);
    send(8'h41);
    send(8'h42);
    send(8'h08);
    send(8'h43);
    idle(20);
    check("BS LINE0", LINE0, {16'h4143, {14{8'h20}}});
    check("BS CUR_COL", CUR_COL, 4'd2);

    // Four LF wrap back to a blanked row 0
    send(8'h0C);
    send(8'h58);
    for (int i = 0; i < 4; i++) send(8'h0A);
    idle(20);
    check("LF wrap cursor", {CUR_ROW, CUR_COL}, 6'd0);
    check("LF wrap LINE0", LINE0, BLANK);

    // Framing error, then a good 0x5A
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h33, 1'b0);
    idle(20);
    check("ferr pulses", n_ferr - f0, 1);
    check("ferr no valid", n_valid - v0, 0);
    check("ferr no write", LINE0, BLANK);
    send(8'h5A);
    idle(20);
    check("after ferr valid", n_valid - v0, 1);
    check("after ferr byte", RX_BYTE, 8'h5A);
    check("after ferr LINE0", LINE0, {8'h5A, {15{8'h20}}});

    // Three-cycle glitch is rejected
    v0 = n_valid;
    f0 = n_ferr;
    drive(1'b0, 3);
    idle(30);
    check("glitch valid", n_valid - v0, 0);
    check("glitch ferr", n_ferr - f0, 0);

    // Reset in the middle of the data bits
    v0 = n_valid;
    drive(1'b0, 10);
    drive(1'b1, 10);
    drive(1'b0, 10);
    RST = 1'b1;
    RX  = 1'b1;
    repeat (3) @(negedge GCLK);
    RST = 1'b0;
    @(negedge GCLK);
    check("midrst LINE0", LINE0, BLANK);
    check("midrst LINE1", LINE1, BLANK);
    check("midrst RX_BYTE", RX_BYTE, 8'h00);
    check("midrst cursor", {CUR_ROW, CUR_COL}, 6'd0);
    check("midrst flags", {RX_VALID, FRAME_ERR}, 2'b00);
    idle(20);
    check("midrst no pulse", n_valid - v0, 0);
    send(8'h41);
    idle(20);
    check("post-rst byte", RX_BYTE, 8'h41);
    check("post-rst LINE0", LINE0, {8'h41, {15{8'h20}}});
    check("post-rst col", CUR_COL, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
